// File: rtl/mc_controller.sv
// Multicycle RV32I control sequencer with memory-ready stall handshake.
// Moore FSM drives datapath selects; aludec turns ALUOp into ALUControl.
module aludec (
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  logic rsub;

  assign rsub = op5 & funct7b5;

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alucontrol = rsub ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase
  end

endmodule

module mc_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [3:0] state;
  logic [3:0] state_n;
  logic       ready;
  logic       pcupdate;
  logic       branch;
  logic       irw;
  logic       rw;
  logic       mw;
  logic       ill;
  logic [1:0] aluop;

  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_R:              state_n = S_EXECR;
          OP_IMM, OP_LUI:    state_n = S_EXECI;
          OP_BR:             state_n = S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          default:           state_n = S_FETCH;
        endcase
      end
      S_MEMADR: state_n = op[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_n = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_n = S_FETCH;
      S_MEMWR:  state_n = ready ? S_FETCH : S_MEMWR;
      S_EXECR:  state_n = S_ALUWB;
      S_EXECI:  state_n = S_ALUWB;
      S_ALUWB:  state_n = S_FETCH;
      S_BRANCH: state_n = S_FETCH;
      S_JAL:    state_n = S_ALUWB;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc    = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    rw        = 1'b0;
    aluop     = 2'b00;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    ill       = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = ready;
        pcupdate  = ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE, OP_R, OP_IMM,
          OP_LUI, OP_BR, OP_JAL: ill = 1'b0;
          default:              ill = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        // lui adds the U-immediate to a forced zero operand
        if (op == OP_LUI) begin
          ALUSrcA = 2'b11;
          aluop   = 2'b00;
        end else begin
          ALUSrcA = 2'b10;
          aluop   = 2'b10;
        end
      end
      S_ALUWB: rw = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      default: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE: ImmSrc = 3'b001;
      OP_BR:    ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      OP_LUI:   ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase
  end

  aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (aluop),
    .alucontrol (ALUControl)
  );

  // enables are gated so nothing writes while reset is held
  assign PCWrite   = ~reset & (pcupdate | (branch & (Zero ^ funct3[0])));
  assign IRWrite   = ~reset & irw;
  assign RegWrite  = ~reset & rw;
  assign MemWrite  = ~reset & mw;
  assign IllegalOp = ~reset & ill;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against a per-instruction cycle model.
// Each instruction class expands into its expected cycle-by-cycle outputs.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       IllegalOp;

  int total;
  int bad;

  mc_controller #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .IllegalOp  (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] v;
    logic        mr;
    string       nm;
  } step_t;

  step_t plan[$];

  // field order: pc adr mw ir res[2] a[2] b[2] rw alu[3] ill
  function automatic logic [14:0] mk(
    logic pc, logic adr, logic mw, logic ir, logic [1:0] res,
    logic [1:0] a, logic [1:0] b, logic rw, logic [2:0] alu,
    logic ill);
    return {pc, adr, mw, ir, res, a, b, rw, alu, ill};
  endfunction

  function automatic logic [14:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
            ALUSrcA, ALUSrcB, RegWrite, ALUControl, IllegalOp};
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    if (o == 7'b0110111) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] alu_fn(logic [6:0] o, logic [2:0] f3,
                                        logic f7);
    if (f3 == 3'b000) return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic void add(logic [14:0] v, logic mr, string nm);
    step_t s;
    s.v = v;
    s.mr = mr;
    s.nm = nm;
    plan.push_back(s);
  endfunction

  // Build the expected cycle list of one instruction, then play it.
  task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7,
                           logic z, int fst, int mst);
    logic mem_op;
    plan.delete();
    for (int i = 0; i < fst; i++)
      add(mk(0,0,0,0,2'b10,2'b00,2'b10,0,3'b000,0), 1'b0, "fetch_stall");
    add(mk(1,0,0,1,2'b10,2'b00,2'b10,0,3'b000,0), 1'b1, "fetch");
    mem_op = (o == 7'b0000011) || (o == 7'b0100011);
    case (o)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b0110111, 7'b1100011, 7'b1101111:
        add(mk(0,0,0,0,2'b00,2'b01,2'b01,0,3'b000,0), 1'($urandom),
            "decode");
      default:
        add(mk(0,0,0,0,2'b00,2'b01,2'b01,0,3'b000,1), 1'($urandom),
            "decode_ill");
    endcase
    if (mem_op)
      add(mk(0,0,0,0,2'b00,2'b10,2'b01,0,3'b000,0), 1'($urandom),
          "memadr");
    if (o == 7'b0000011) begin
      for (int i = 0; i < mst; i++)
        add(mk(0,1,0,0,2'b00,2'b00,2'b00,0,3'b000,0), 1'b0, "memrd_stall");
      add(mk(0,1,0,0,2'b00,2'b00,2'b00,0,3'b000,0), 1'b1, "memrd");
      add(mk(0,0,0,0,2'b01,2'b00,2'b00,1,3'b000,0), 1'($urandom),
          "memwb");
    end
    if (o == 7'b0100011) begin
      for (int i = 0; i < mst; i++)
        add(mk(0,1,1,0,2'b00,2'b00,2'b00,0,3'b000,0), 1'b0, "memwr_stall");
      add(mk(0,1,1,0,2'b00,2'b00,2'b00,0,3'b000,0), 1'b1, "memwr");
    end
    if (o == 7'b0110011)
      add(mk(0,0,0,0,2'b00,2'b10,2'b00,0,alu_fn(o,f3,f7),0),
          1'($urandom), "execr");
    if (o == 7'b0010011)
      add(mk(0,0,0,0,2'b00,2'b10,2'b01,0,alu_fn(o,f3,f7),0),
          1'($urandom), "execi");
    if (o == 7'b0110111)
      add(mk(0,0,0,0,2'b00,2'b11,2'b01,0,3'b000,0), 1'($urandom),
          "exec_lui");
    if (o == 7'b1101111)
      add(mk(1,0,0,0,2'b00,2'b01,2'b10,0,3'b000,0), 1'($urandom), "jal");
    if (o == 7'b1100011)
      add(mk(z ^ f3[0],0,0,0,2'b00,2'b10,2'b00,0,3'b001,0),
          1'($urandom), "branch");
    if (o inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111})
      add(mk(0,0,0,0,2'b00,2'b00,2'b00,1,3'b000,0), 1'($urandom), "aluwb");
    foreach (plan[k]) begin
      @(negedge clk);
      op = o;
      funct3 = f3;
      funct7b5 = f7;
      Zero = z;
      MemReady = plan[k].mr;
      #1;
      total++;
      if (actual() !== plan[k].v) begin
        bad++;
        $display("FAIL %s op=%b: got %b want %b", plan[k].nm, o,
                 actual(), plan[k].v);
      end
      total++;
      if (ImmSrc !== imm_of(o)) begin
        bad++;
        $display("FAIL immsrc op=%b: got %b want %b", o, ImmSrc,
                 imm_of(o));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op = 7'b0110011;
    funct3 = 3'b000;
    funct7b5 = 1'b0;
    Zero = 1'b1;
    MemReady = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      total++;
      if (actual() !== mk(0,0,0,0,2'b10,2'b00,2'b10,0,3'b000,0)) begin
        bad++;
        $display("FAIL reset_hold: got %b", actual());
      end
    end
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
  endtask

  task automatic test_reset_mid_memwr();
    plan.delete();
    @(negedge clk);
    op = 7'b0100011;
    MemReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    total++;
    if (MemWrite !== 1'b1 || AdrSrc !== 1'b1) begin
      bad++;
      $display("FAIL in_memwr: mw=%b adr=%b want 1 1", MemWrite, AdrSrc);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_memwr_drop: mw=%b want 0", MemWrite);
    end
    MemReady = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      total++;
      if (actual() !== mk(0,0,0,0,2'b10,2'b00,2'b10,0,3'b000,0)) begin
        bad++;
        $display("FAIL reset_mid_hold: got %b", actual());
      end
    end
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    #1;
    total++;
    if (actual() !== mk(0,0,0,0,2'b10,2'b00,2'b10,0,3'b000,0)) begin
      bad++;
      $display("FAIL reset_release_fetch: got %b", actual());
    end
  endtask

  task automatic test_rtype();
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_lw_stall();
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 1);
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_jal();
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b0110111, 7'b1100011, 7'b1101111, 7'b0000000};
    for (int n = 0; n < 200; n++)
      run_instr(ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
                1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_reset_mid_memwr();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_jal();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
